// File: rtl/fft_sample_unpacker.sv
// fft_sample_unpacker: pops 64-bit FIFO words and streams them out as two
// 32-bit complex samples each (lower lane first) on an AXI4-Stream master.
// TLAST marks every FFT frame boundary and the final sample of the job.
module fft_sample_unpacker #(
    parameter int C_DATA_WIDTH   = 64,
    parameter int C_SAMPLE_WIDTH = 32,
    parameter int C_FFT_LEN      = 1024,
    parameter int C_LOG2_FFT_LEN = 10
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst,
    input  logic                      ap_start,
    output logic                      ap_done,
    output logic                      ap_idle,
    output logic                      ap_ready,
    input  logic [31:0]               transfer_byte,
    input  logic [C_DATA_WIDTH-1:0]   in_r_dout,
    input  logic                      in_r_empty_n,
    output logic                      in_r_read,
    output logic [C_SAMPLE_WIDTH-1:0] m_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tlast
);

    typedef enum logic [1:0] {S_IDLE, S_PRE, S_RUN, S_DONE} state_t;

    localparam logic [C_LOG2_FFT_LEN-1:0] FRM_LAST = C_LOG2_FFT_LEN'(C_FFT_LEN - 1);

    state_t                      state_q, state_d;
    logic                        start_q, start_d;
    logic [31:0]                 xfer_q, xfer_d;
    logic [31:0]                 total_smp_q, total_smp_d;
    logic [31:0]                 total_wrd_q, total_wrd_d;
    logic [31:0]                 smp_cnt_q, smp_cnt_d;
    logic [31:0]                 wrd_cnt_q, wrd_cnt_d;
    logic [C_LOG2_FFT_LEN-1:0]   frm_pos_q, frm_pos_d;
    logic [C_DATA_WIDTH-1:0]     buf_q, buf_d;
    logic                        bvld_q, bvld_d;
    logic                        lane_q, lane_d;

    logic start_rise, hs, last_smp, buf_free, load_ok;

    // hs is built from internal state rather than m_axis_tvalid so the
    // output process does not feed back into itself through load_ok.
    assign start_rise = ap_start & ~start_q;
    assign hs         = (state_q == S_RUN) & bvld_q & m_axis_tready;
    assign last_smp   = (smp_cnt_q == total_smp_q - 32'd1);
    assign buf_free   = hs & (lane_q | last_smp);
    assign load_ok    = (state_q == S_RUN) && (wrd_cnt_q < total_wrd_q) && (!bvld_q || buf_free);

    // FSM state register
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start_rise) state_d = S_PRE;
            S_PRE:  state_d = (xfer_q[31:2] == 30'd0) ? S_DONE : S_RUN;
            S_RUN:  if (hs && last_smp) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM / stream outputs
    always_comb begin
        ap_idle       = (state_q == S_IDLE);
        ap_ready      = (state_q == S_PRE);
        ap_done       = (state_q == S_DONE);
        m_axis_tvalid = (state_q == S_RUN) & bvld_q;
        m_axis_tdata  = lane_q ? buf_q[C_SAMPLE_WIDTH +: C_SAMPLE_WIDTH] : buf_q[C_SAMPLE_WIDTH-1:0];
        m_axis_tlast  = m_axis_tvalid & ((frm_pos_q == FRM_LAST) | last_smp);
        in_r_read     = load_ok & in_r_empty_n;
    end

    // Datapath next-state: job sizing, counters and the word buffer
    always_comb begin
        start_d     = ap_start;
        xfer_d      = xfer_q;
        total_smp_d = total_smp_q;
        total_wrd_d = total_wrd_q;
        smp_cnt_d   = smp_cnt_q;
        wrd_cnt_d   = wrd_cnt_q;
        frm_pos_d   = frm_pos_q;
        buf_d       = buf_q;
        bvld_d      = bvld_q;
        lane_d      = lane_q;

        if (state_q == S_IDLE && start_rise) xfer_d = transfer_byte;

        if (state_q == S_PRE) begin
            total_smp_d = {2'b00, xfer_q[31:2]};
            // 33-bit sum so a near-max byte count cannot wrap
            total_wrd_d = 32'(({1'b0, xfer_q} + 33'd4) >> 3);
        end

        if (state_q == S_IDLE) begin
            smp_cnt_d = '0;
            wrd_cnt_d = '0;
            frm_pos_d = '0;
            buf_d     = '0;
            bvld_d    = 1'b0;
            lane_d    = 1'b0;
        end else begin
            if (hs) begin
                smp_cnt_d = smp_cnt_q + 32'd1;
                frm_pos_d = frm_pos_q + C_LOG2_FFT_LEN'(1);
            end
            // A load overrides the free/advance so word boundaries have no bubble
            if (in_r_read) begin
                buf_d     = in_r_dout;
                bvld_d    = 1'b1;
                lane_d    = 1'b0;
                wrd_cnt_d = wrd_cnt_q + 32'd1;
            end else if (hs) begin
                if (buf_free) bvld_d = 1'b0;
                else          lane_d = 1'b1;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            start_q     <= 1'b0;
            xfer_q      <= '0;
            total_smp_q <= '0;
            total_wrd_q <= '0;
            smp_cnt_q   <= '0;
            wrd_cnt_q   <= '0;
            frm_pos_q   <= '0;
            buf_q       <= '0;
            bvld_q      <= 1'b0;
            lane_q      <= 1'b0;
        end else begin
            start_q     <= start_d;
            xfer_q      <= xfer_d;
            total_smp_q <= total_smp_d;
            total_wrd_q <= total_wrd_d;
            smp_cnt_q   <= smp_cnt_d;
            wrd_cnt_q   <= wrd_cnt_d;
            frm_pos_q   <= frm_pos_d;
            buf_q       <= buf_d;
            bvld_q      <= bvld_d;
            lane_q      <= lane_d;
        end
    end

endmodule

// File: tb/tb_fft_sample_unpacker.sv
// Bench for fft_sample_unpacker: a queue-based FIFO model feeds random words,
// the expected sample stream is the words split into lanes, truncated to the
// job length; TLAST is expected on beat%1024==1023 or the last beat.
module tb_fft_sample_unpacker;
    localparam int FFT = 1024;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic        ap_start;
    logic        ap_done, ap_idle, ap_ready;
    logic [31:0] transfer_byte;
    logic [63:0] in_r_dout;
    logic        in_r_empty_n;
    logic        in_r_read;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;

    int total = 0;
    int bad   = 0;

    logic [63:0] fifo_q[$];
    logic [31:0] exp_q[$];

    fft_sample_unpacker dut (
        .ap_clk        (ap_clk),
        .ap_rst        (ap_rst),
        .ap_start      (ap_start),
        .ap_done       (ap_done),
        .ap_idle       (ap_idle),
        .ap_ready      (ap_ready),
        .transfer_byte (transfer_byte),
        .in_r_dout     (in_r_dout),
        .in_r_empty_n  (in_r_empty_n),
        .in_r_read     (in_r_read),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_last(input int b, input int n);
        return ((b % FFT) == FFT - 1) || (b == n - 1);
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_done"},   32'(ap_done),       32'd0);
        chk({tag, "_idle"},   32'(ap_idle),       32'd1);
        chk({tag, "_ready"},  32'(ap_ready),      32'd0);
        chk({tag, "_read"},   32'(in_r_read),     32'd0);
        chk({tag, "_tvalid"}, 32'(m_axis_tvalid), 32'd0);
        chk({tag, "_tlast"},  32'(m_axis_tlast),  32'd0);
        chk({tag, "_tdata"},  m_axis_tdata,       32'd0);
    endtask

    // mode 0: FIFO always non-empty, tready=1
    // mode 1: fixed word, tready low 3 cycles while the upper lane is held
    // mode 2: random tready / empty_n
    // abort_cyc != 0: leave the job at that cycle (caller pulses reset)
    task automatic run_job(input string tag, input int nbytes, input int mode,
                           input int abort_cyc, input logic [63:0] fixed_word,
                           input int exp_lasts);
        int smp, nw, beats, pops, lasts, errs, rd_empty, readies, dones;
        int first_cyc, last_cyc, stalls, tail, budget;
        logic rd_now;
        logic [63:0] w;
        smp = nbytes / 4;
        nw  = (smp + 1) / 2;
        fifo_q.delete();
        exp_q.delete();
        for (int i = 0; i < nw; i++) begin
            w = (mode == 1) ? fixed_word : {$urandom, $urandom};
            fifo_q.push_back(w);
        end
        for (int i = 0; i < smp; i++) begin
            w = fifo_q[i / 2];
            exp_q.push_back((i % 2 == 1) ? w[63:32] : w[31:0]);
        end
        beats = 0; pops = 0; lasts = 0; errs = 0; rd_empty = 0;
        readies = 0; dones = 0; first_cyc = -1; last_cyc = -1; stalls = 0; tail = -1;
        budget = smp * 8 + 64;
        transfer_byte = 32'(nbytes);
        for (int cyc = 0; cyc < budget; cyc++) begin
            @(negedge ap_clk);
            if (abort_cyc != 0 && cyc == abort_cyc) break;
            ap_start = (cyc == 0);
            case (mode)
                1: m_axis_tready = !(beats == 1 && stalls < 3);
                2: m_axis_tready = ($urandom_range(0, 9) < 6);
                default: m_axis_tready = 1'b1;
            endcase
            if (mode == 1 && !m_axis_tready) stalls++;
            in_r_empty_n = (mode == 2) ? ($urandom_range(0, 9) < 7) : 1'b1;
            in_r_dout    = (fifo_q.size() > 0) ? fifo_q[0] : 64'hDEAD_BEEF_0BAD_F00D;
            #1;
            if (ap_ready) readies++;
            if (ap_done) begin
                dones++;
                tail = cyc + 4;
            end
            rd_now = in_r_read;
            if (in_r_read) begin
                pops++;
                if (!in_r_empty_n) rd_empty++;
            end
            if (m_axis_tvalid) begin
                if (beats >= smp) errs++;
                else begin
                    if (m_axis_tdata !== exp_q[beats]) errs++;
                    if (m_axis_tlast !== exp_last(beats, smp)) errs++;
                end
                if (m_axis_tready) begin
                    if (m_axis_tlast) lasts++;
                    if (first_cyc < 0) first_cyc = cyc;
                    last_cyc = cyc;
                    beats++;
                end
            end
            @(posedge ap_clk);
            if (rd_now && fifo_q.size() > 0) void'(fifo_q.pop_front());
            if (cyc == tail) break;
        end
        ap_start = 1'b0;
        if (abort_cyc != 0) begin
            chk({tag, "_beats_so_far"}, 32'(errs), 32'd0);
            return;
        end
        chk({tag, "_data_tlast_errs"}, 32'(errs), 32'd0);
        chk({tag, "_beats"}, 32'(beats), 32'(smp));
        chk({tag, "_pops"}, 32'(pops), 32'(nw));
        chk({tag, "_pop_on_empty"}, 32'(rd_empty), 32'd0);
        chk({tag, "_tlast_count"}, 32'(lasts), 32'(exp_lasts));
        chk({tag, "_ready_pulses"}, 32'(readies), 32'd1);
        chk({tag, "_done_pulses"}, 32'(dones), 32'd1);
        if (mode == 0 && smp > 0)
            chk({tag, "_gapless"}, 32'(last_cyc - first_cyc + 1), 32'(smp));
        if (mode == 1)
            chk({tag, "_stall_cycles"}, 32'(stalls), 32'd3);
    endtask

    initial begin
        ap_rst        = 1'b1;
        ap_start      = 1'b0;
        transfer_byte = '0;
        in_r_dout     = '0;
        in_r_empty_n  = 1'b1;
        m_axis_tready = 1'b1;
        repeat (3) @(negedge ap_clk);
        chk_reset_vals("rst");
        ap_rst = 1'b0;
        @(negedge ap_clk);
        #1;
        chk_reset_vals("post_rst_idle");

        run_job("full2048", 8192, 0, 0, 64'h0, 2);
        run_job("word_stall", 8, 1, 0, 64'h0002_0001_0004_0003, 1);
        run_job("odd3", 12, 0, 0, 64'h0, 1);
        run_job("zero", 0, 0, 0, 64'h0, 0);
        for (int j = 0; j < 3; j++)
            run_job($sformatf("rand1500_%0d", j), 6000, 2, 0, 64'h0, 2);

        // Reset mid-burst, away from any clock edge
        run_job("abort", 8192, 0, 300, 64'h0, 0);
        #2 ap_rst = 1'b1;
        #1;
        chk_reset_vals("async_rst");
        repeat (2) @(negedge ap_clk);
        ap_rst = 1'b0;
        run_job("after_rst", 8192, 0, 0, 64'h0, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
